wb_cfg_arbiter: RTL and testbench

WB_CFG_ARBITER -- requirements
Module: wb_cfg_arbiter

---
 rtl/wb_cfg_arb_pkg.sv | 24 ++
 rtl/wb_cfg_arbiter_if.sv | 34 +++
 rtl/rr_arb2.sv | 39 +++
 rtl/wb_cfg_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_wb_cfg_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_cfg_arb_pkg.sv
// wb_cfg_arb_pkg
// Shared definitions for the Wishbone configuration arbiter:
//   - FSM state encodings (plain 2-bit constants plus a matching enum for debug views)
//   - WB_SEL_ALL : byte-select value driven on every access (always full word)
//   - CNT_W      : width of the ack-timeout counter (TIMEOUT is limited to 1..255)
package wb_cfg_arb_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  localparam int CNT_W = 8;

endpackage

// File: rtl/wb_cfg_arbiter_if.sv
// wb_cfg_arbiter_if
// Wishbone classic/pipelined master bus used between the arbiter and a
// configuration slave.
//   master modport : drives cyc/stb/we/adr/sel/dat, receives ack/err/rty/stall/dat
//   slave  modport : the mirror image
// Signal names keep the master-side _o/_i suffixes so they read the same in
// the arbiter and on the bus.
interface wb_cfg_arbiter_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin grant with a last-grant pointer.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_req[1:0]   : request vector
//   i_adv        : a grant was taken this cycle; update the pointer
//   o_gnt[1:0]   : one-hot (or zero) grant, combinational
// The pointer resets to 1 so requester 0 wins the first contended cycle.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  logic r_last;

  // Grant select: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = r_last ? 2'b01 : 2'b10;
    end else begin
      o_gnt = i_req;
    end
  end

  // Last-grant pointer, updated only when the grant is actually consumed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (i_adv) begin
      r_last <= o_gnt[1];
    end else begin
      r_last <= r_last;
    end
  end

endmodule

// File: rtl/wb_cfg_arbiter.sv
// wb_cfg_arbiter
// Arbitrates two simple request/response ports onto one Wishbone master bus,
// one transaction at a time.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   reqN_valid/we/adr/dat : request from requester N (N = 0,1)
//   reqN_ready_o          : request accepted this cycle (combinational, IDLE only)
//   rspN_valid/dat/err_o  : one-cycle response pulse; dat/err hold between pulses
//   wb                    : Wishbone master bus (wb_cfg_arbiter_if.master)
// Parameters: ADDR_WIDTH (bus address width), TIMEOUT (ack wait limit, 1..255).
module wb_cfg_arbiter
  import wb_cfg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_adr_i,
  input  logic [31:0]           req0_dat_i,
  output logic                  req0_ready_o,
  output logic                  rsp0_valid_o,
  output logic [31:0]           rsp0_dat_o,
  output logic                  rsp0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_adr_i,
  input  logic [31:0]           req1_dat_i,
  output logic                  req1_ready_o,
  output logic                  rsp1_valid_o,
  output logic [31:0]           rsp1_dat_o,
  output logic                  rsp1_err_o,
  wb_cfg_arbiter_if.master      wb
);

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_gnt_idx;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_rsp_valid;
  logic [31:0]           r_rsp0_dat;
  logic [31:0]           r_rsp1_dat;
  logic                  r_rsp0_err;
  logic                  r_rsp1_err;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_done_err;
  logic [31:0]           w_done_dat;
  logic                  w_bus_term;

  rr_arb2 u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_req ({req1_valid_i, req0_valid_i}),
    .i_adv (w_accept),
    .o_gnt (w_gnt)
  );

  // Ready is gated with rst_i so it is low while reset is held, not just after.
  assign req0_ready_o = (r_state == S_IDLE) && w_gnt[0] && !rst_i;
  assign req1_ready_o = (r_state == S_IDLE) && w_gnt[1] && !rst_i;
  assign w_accept     = req0_ready_o || req1_ready_o;

  assign w_bus_term = wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i;

  // Completion detect: slave termination (ack beats err/rty) or wait timeout.
  always_comb begin
    w_done     = 1'b0;
    w_done_err = 1'b0;
    w_done_dat = 32'd0;
    case (r_state)
      S_STROBE: begin
        if (!wb.wb_stall_i && w_bus_term) begin
          w_done     = 1'b1;
          w_done_err = !wb.wb_ack_i;
          w_done_dat = (wb.wb_ack_i && !r_we) ? wb.wb_dat_i : 32'd0;
        end else begin
          w_done = 1'b0;
        end
      end
      S_WAIT: begin
        if (w_bus_term) begin
          w_done     = 1'b1;
          w_done_err = !wb.wb_ack_i;
          w_done_dat = (wb.wb_ack_i && !r_we) ? wb.wb_dat_i : 32'd0;
        end else if (r_cnt == TIMEOUT_M1) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end else begin
          w_done = 1'b0;
        end
      end
      default: begin
        w_done = 1'b0;
      end
    endcase
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_accept ? S_STROBE : S_IDLE;
      S_STROBE: begin
        if (wb.wb_stall_i) begin
          w_state_nxt = S_STROBE;
        end else begin
          w_state_nxt = w_done ? S_RESP : S_WAIT;
        end
      end
      S_WAIT:   w_state_nxt = w_done ? S_RESP : S_WAIT;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter: zero outside WAIT, so it is clear on every WAIT entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= {CNT_W{1'b0}};
    end
  end

  // Request latch and owner, captured at accept and held for the whole transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt_idx <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= {ADDR_WIDTH{1'b0}};
      r_dat     <= 32'd0;
    end else if (w_accept) begin
      r_gnt_idx <= w_gnt[1];
      r_we      <= w_gnt[1] ? req1_we_i  : req0_we_i;
      r_adr     <= w_gnt[1] ? req1_adr_i : req0_adr_i;
      r_dat     <= w_gnt[1] ? req1_dat_i : req0_dat_i;
    end else begin
      r_gnt_idx <= r_gnt_idx;
      r_we      <= r_we;
      r_adr     <= r_adr;
      r_dat     <= r_dat;
    end
  end

  // Response registers: valid pulses during RESP, data/err hold until the next response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 2'b00;
      r_rsp0_dat  <= 32'd0;
      r_rsp1_dat  <= 32'd0;
      r_rsp0_err  <= 1'b0;
      r_rsp1_err  <= 1'b0;
    end else begin
      r_rsp_valid <= 2'b00;
      if (w_done) begin
        if (r_gnt_idx) begin
          r_rsp_valid[1] <= 1'b1;
          r_rsp1_dat     <= w_done_dat;
          r_rsp1_err     <= w_done_err;
        end else begin
          r_rsp_valid[0] <= 1'b1;
          r_rsp0_dat     <= w_done_dat;
          r_rsp0_err     <= w_done_err;
        end
      end else begin
        r_rsp0_dat <= r_rsp0_dat;
        r_rsp1_dat <= r_rsp1_dat;
        r_rsp0_err <= r_rsp0_err;
        r_rsp1_err <= r_rsp1_err;
      end
    end
  end

  assign rsp0_valid_o = r_rsp_valid[0];
  assign rsp1_valid_o = r_rsp_valid[1];
  assign rsp0_dat_o   = r_rsp0_dat;
  assign rsp1_dat_o   = r_rsp1_dat;
  assign rsp0_err_o   = r_rsp0_err;
  assign rsp1_err_o   = r_rsp1_err;

  // cyc/stb decode straight from the state flop, so an async reset drops them at once.
  assign wb.wb_cyc_o = (r_state == S_STROBE) || (r_state == S_WAIT);
  assign wb.wb_stb_o = (r_state == S_STROBE);
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_dat_o = r_dat;
  assign wb.wb_sel_o = rst_i ? 4'b0000 : WB_SEL_ALL;

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// tb_wb_cfg_arbiter
// Self-checking bench: a behavioural Wishbone register slave with configurable
// stall/latency/termination, a reference model (round-robin pointer, register
// image, timeout rule) and directed plus randomized transactions.
module tb_wb_cfg_arbiter;

  localparam int AW     = 4;
  localparam int TO     = 4;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_RTY  = 2;
  localparam int K_NONE = 3;

  logic          clk;
  logic          rst_i;
  logic          req0_valid_i, req0_we_i, req0_ready_o, rsp0_valid_o, rsp0_err_o;
  logic [AW-1:0] req0_adr_i;
  logic [31:0]   req0_dat_i, rsp0_dat_o;
  logic          req1_valid_i, req1_we_i, req1_ready_o, rsp1_valid_o, rsp1_err_o;
  logic [AW-1:0] req1_adr_i;
  logic [31:0]   req1_dat_i, rsp1_dat_o;

  wb_cfg_arbiter_if #(.ADDR_WIDTH(AW)) wb_bus ();

  wb_cfg_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_we_i    (req0_we_i),
    .req0_adr_i   (req0_adr_i),
    .req0_dat_i   (req0_dat_i),
    .req0_ready_o (req0_ready_o),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_dat_o   (rsp0_dat_o),
    .rsp0_err_o   (rsp0_err_o),
    .req1_valid_i (req1_valid_i),
    .req1_we_i    (req1_we_i),
    .req1_adr_i   (req1_adr_i),
    .req1_dat_i   (req1_dat_i),
    .req1_ready_o (req1_ready_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_dat_o   (rsp1_dat_o),
    .rsp1_err_o   (rsp1_err_o),
    .wb           (wb_bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          last_gnt;
  logic [31:0] mdl_mem [16];
  logic [31:0] rsp_dat_exp [2];

  // Slave configuration and the request it should see on the bus.
  int          cfg_stall, cfg_dly, cfg_kind;
  logic        exp_we;
  logic [AW-1:0] exp_adr;
  logic [31:0] exp_dat;
  logic [31:0] slv_mem [16];
  int          st_cnt, wt_cnt;
  logic        prev_stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic slv_present();
    chk("bus_adr", 32'(wb_bus.wb_adr_o), 32'(exp_adr));
    chk("bus_we", 32'(wb_bus.wb_we_o), 32'(exp_we));
    chk("bus_sel", 32'(wb_bus.wb_sel_o), 32'hF);
    if (exp_we) chk("bus_wdat", wb_bus.wb_dat_o, exp_dat);
    case (cfg_kind)
      K_ACK: begin
        wb_bus.wb_ack_i = 1'b1;
        if (wb_bus.wb_we_o) slv_mem[wb_bus.wb_adr_o] = wb_bus.wb_dat_o;
        else wb_bus.wb_dat_i = slv_mem[wb_bus.wb_adr_o];
      end
      K_ERR:   wb_bus.wb_err_i = 1'b1;
      K_RTY:   wb_bus.wb_rty_i = 1'b1;
      default: ;
    endcase
  endtask

  // Behavioural slave: decides its outputs on the falling edge for the next rising edge.
  initial begin
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'd0;
    wb_bus.wb_ack_i = 1'b0; wb_bus.wb_err_i = 1'b0; wb_bus.wb_rty_i = 1'b0;
    wb_bus.wb_stall_i = 1'b0; wb_bus.wb_dat_i = 32'd0;
    st_cnt = 0; wt_cnt = 0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_bus.wb_cyc_o && prev_stall) begin
        chk("stall_stb", 32'(wb_bus.wb_stb_o), 32'd1);
        chk("stall_adr", 32'(wb_bus.wb_adr_o), 32'(exp_adr));
        chk("stall_dat", wb_bus.wb_dat_o, exp_dat);
      end
      wb_bus.wb_ack_i = 1'b0; wb_bus.wb_err_i = 1'b0; wb_bus.wb_rty_i = 1'b0;
      wb_bus.wb_dat_i = $urandom();
      if (!wb_bus.wb_cyc_o) begin
        wb_bus.wb_stall_i = 1'b0; st_cnt = 0; wt_cnt = 0;
      end else if (wb_bus.wb_stb_o) begin
        if (st_cnt < cfg_stall) begin
          wb_bus.wb_stall_i = 1'b1; st_cnt++;
        end else begin
          wb_bus.wb_stall_i = 1'b0;
          if (cfg_dly == 0) slv_present();
        end
      end else begin
        wb_bus.wb_stall_i = 1'b0; wt_cnt++;
        if (wt_cnt == cfg_dly) slv_present();
      end
      prev_stall = wb_bus.wb_stall_i;
    end
  end

  // One complete transaction: drive, predict, wait for the response, compare.
  task automatic run_txn(input logic v0, input logic v1, input logic we0, input logic we1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int stall, input int dly, input int kind);
    int g, exp_lat, k;
    logic we, e_err, seen;
    logic [AW-1:0] a;
    logic [31:0] d, e_dat;
    if (v0 && v1) g = (last_gnt == 1) ? 0 : 1;
    else g = v1 ? 1 : 0;
    we = (g == 1) ? we1 : we0;
    a  = (g == 1) ? a1 : a0;
    d  = (g == 1) ? d1 : d0;
    if (kind != K_NONE && dly <= TO) begin
      exp_lat = stall + 1 + dly;
      if (kind == K_ACK) begin
        e_err = 1'b0;
        e_dat = we ? 32'd0 : mdl_mem[a];
        if (we) mdl_mem[a] = d;
      end else begin
        e_err = 1'b1; e_dat = 32'd0;
      end
    end else begin
      exp_lat = stall + 1 + TO; e_err = 1'b1; e_dat = 32'd0;
    end
    cfg_stall = stall; cfg_dly = dly; cfg_kind = kind;
    exp_we = we; exp_adr = a; exp_dat = d;
    @(negedge clk);
    req0_valid_i = v0; req0_we_i = we0; req0_adr_i = a0; req0_dat_i = d0;
    req1_valid_i = v1; req1_we_i = we1; req1_adr_i = a1; req1_dat_i = d1;
    #1;
    chk("ready0", 32'(req0_ready_o), 32'(g == 0));
    chk("ready1", 32'(req1_ready_o), 32'(g == 1));
    @(posedge clk);
    last_gnt = g;
    k = 0; seen = 1'b0;
    while (!seen && k < 60) begin
      @(posedge clk); k++;
      @(negedge clk);
      chk("busy_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
      if (rsp0_valid_o || rsp1_valid_o) seen = 1'b1;
    end
    if (!seen) begin
      chk("rsp_seen", 32'd0, 32'd1);
    end else begin
      chk("rsp_valid", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd1 << g);
      chk("rsp_dat", (g == 1) ? rsp1_dat_o : rsp0_dat_o, e_dat);
      chk("rsp_err", 32'((g == 1) ? rsp1_err_o : rsp0_err_o), 32'(e_err));
      chk("latency", 32'(k), 32'(exp_lat));
      chk("other_hold", (g == 1) ? rsp0_dat_o : rsp1_dat_o, rsp_dat_exp[1 - g]);
      rsp_dat_exp[g] = e_dat;
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk);
    chk("pulse_end", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
    chk("dat_hold", (g == 1) ? rsp1_dat_o : rsp0_dat_o, rsp_dat_exp[g]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cyc"}, 32'(wb_bus.wb_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(wb_bus.wb_stb_o), 32'd0);
    chk({tag, "_sel"}, 32'(wb_bus.wb_sel_o), 32'd0);
    chk({tag, "_rdy"}, 32'({req1_ready_o, req0_ready_o}), 32'd0);
    chk({tag, "_rspv"}, 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
    chk({tag, "_rsp0d"}, rsp0_dat_o, 32'd0);
    chk({tag, "_rsp1d"}, rsp1_dat_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic v0, v1;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
    rsp_dat_exp[0] = 32'd0; rsp_dat_exp[1] = 32'd0;
    last_gnt = 1;
    cfg_stall = 0; cfg_dly = 0; cfg_kind = K_ACK;
    exp_we = 1'b0; exp_adr = '0; exp_dat = 32'd0;
    rst_i = 1'b1;
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_adr_i = '0; req0_dat_i = 32'd0;
    req1_valid_i = 1'b1; req1_we_i = 1'b0; req1_adr_i = '0; req1_dat_i = 32'd0;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    chk_reset_outputs("por_hold");
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    chk("sel_run", 32'(wb_bus.wb_sel_o), 32'hF);

    // Write then read the threshold register from different requesters.
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 32'hABCD1234, 32'd0, 0, 0, K_ACK);
    chk("sreg_hi", 32'(slv_mem[0][31:16]), 32'hABCD);
    chk("sreg_lo", 32'(slv_mem[0][15:0]), 32'h1234);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 0, 1, K_ACK);

    // Simultaneous pairs alternate.
    for (int i = 0; i < 3; i++)
      run_txn(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'(i + 3), 32'd0, 32'h5A5A0000 + 32'(i), 0, 2, K_ACK);

    // Stall, timeout, error, retry, ack at the timeout boundary.
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 32'hCAFEF00D, 32'd0, 3, 0, K_ACK);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 32'd0, 32'd0, 3, 2, K_ACK);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 32'd0, 32'd0, 0, 0, K_NONE);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 32'd0, 32'd0, 0, 1, K_ERR);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 32'd0, 32'd0, 1, 0, K_RTY);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 32'd0, 32'd0, 0, TO, K_ACK);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 32'd0, 32'd0, 0, TO + 1, K_ACK);

    // Reset while waiting for ack: bus drops at once, no response, pointer restarts.
    cfg_stall = 0; cfg_dly = 0; cfg_kind = K_NONE;
    exp_we = 1'b0; exp_adr = 4'd5; exp_dat = 32'd0;
    @(negedge clk);
    req0_valid_i = 1'b1; req0_we_i = 1'b0; req0_adr_i = 4'd5;
    @(posedge clk);
    k = 0;
    while (!(wb_bus.wb_cyc_o && !wb_bus.wb_stb_o) && k < 10) begin
      @(negedge clk); k++;
    end
    chk("reach_wait", 32'(k < 10), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("mid");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0; req0_valid_i = 1'b0;
    last_gnt = 1; rsp_dat_exp[0] = 32'd0; rsp_dat_exp[1] = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'({rsp1_valid_o, rsp0_valid_o, wb_bus.wb_cyc_o}), 32'd0);
    end
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 32'd0, 32'd0, 0, 0, K_ACK);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int kind, r;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      r = int'($urandom_range(0, 9));
      kind = (r < 7) ? K_ACK : (r == 7) ? K_ERR : (r == 8) ? K_RTY : K_NONE;
      run_txn(v0, v1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              $urandom(), $urandom(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)), kind);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
